// File: rtl/dct_da_pkg.sv
// dct_da_pkg: shared widths, FSM encoding and Z6 coefficients for the DA MAC
package dct_da_pkg;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_ROM_W  = 16;
  localparam int DEF_OUT_W  = DEF_ROM_W + DEF_DATA_W;
  localparam logic signed [15:0] C2_Q14 = 16'sh3B21;
  localparam logic signed [15:0] C6_Q14 = 16'sh187D;
  typedef enum logic [1:0] {WAKE, IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/da_bit_slicer.sv
// da_bit_slicer: three parallel-load shift registers emitting MSB-first address slices
// Ports: clk, rst_n (async, active-low), load (capture xa/xb/xc), shift (advance one bit),
//        xa/xb/xc samples, addr = {xa[msb], xb[msb], xc[msb]} of the current slice.
module da_bit_slicer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] xa,
  input  logic [W-1:0] xb,
  input  logic [W-1:0] xc,
  output logic [2:0]   addr
);
  logic [W-1:0] sa_q, sa_d, sb_q, sb_d, sc_q, sc_d;
  always_comb begin
    sa_d = load ? xa : shift ? sa_q << 1 : sa_q;
    sb_d = load ? xb : shift ? sb_q << 1 : sb_q;
    sc_d = load ? xc : shift ? sc_q << 1 : sc_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa_q <= '0;
      sb_q <= '0;
      sc_q <= '0;
    end else begin
      sa_q <= sa_d;
      sb_q <= sb_d;
      sc_q <= sc_d;
    end
  assign addr = {sa_q[W-1], sb_q[W-1], sc_q[W-1]};
endmodule

// File: rtl/dct_da_bitserial_mac.sv
// dct_da_bitserial_mac: bit-serial distributed-arithmetic MAC for the Z6 DCT lane
// Ports: clk, rst_n (async, active-low); in_valid/in_ready handshake for xa/xb/xc;
//        rom_cs/rom_addr drive the Z6 coefficient ROM, rom_data returns combinationally;
//        out_valid/out_ready handshake for the Q14 result z_out.
module dct_da_bitserial_mac
  import dct_da_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROM_W  = DEF_ROM_W,
  parameter int OUT_W  = ROM_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] xa,
  input  logic [DATA_W-1:0] xb,
  input  logic [DATA_W-1:0] xc,
  output logic              rom_cs,
  output logic [2:0]        rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  z_out
);
  localparam int CNT_W = $clog2(DATA_W);

  if (DATA_W < 2) begin : g_bad_width
    $error("dct_da_bitserial_mac: DATA_W must be at least 2");
  end

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         bit_q, bit_d;
  logic signed [OUT_W-1:0]  acc_q, acc_d, z_q, z_d, rom_ext;
  logic                     load, last;
  logic [2:0]               slice;

  da_bit_slicer #(.W(DATA_W)) u_slicer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (rom_cs),
    .xa    (xa),
    .xb    (xb),
    .xc    (xc),
    .addr  (slice)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= WAKE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAKE:    state_d = IDLE;
      IDLE:    state_d = in_valid ? RUN : IDLE;
      RUN:     state_d = last ? DONE : RUN;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = WAKE;
    endcase
  end

  always_comb begin
    in_ready  = state_q == IDLE;
    rom_cs    = state_q == RUN;
    out_valid = state_q == DONE;
    rom_addr  = rom_cs ? slice : 3'd0;
  end

  // The MSB slice carries negative weight in two's complement, so it seeds acc negated.
  assign rom_ext = {{(OUT_W-ROM_W){rom_data[ROM_W-1]}}, rom_data};
  assign load    = in_ready && in_valid;
  assign last    = rom_cs && bit_q == '0;

  always_comb begin
    acc_d = load ? '0 : !rom_cs ? acc_q :
            bit_q == CNT_W'(DATA_W-1) ? -rom_ext : (acc_q <<< 1) + rom_ext;
    bit_d = load ? CNT_W'(DATA_W-1) : (rom_cs && !last) ? bit_q - CNT_W'(1) : bit_q;
    z_d   = last ? acc_d : z_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q <= '0;
      bit_q <= '0;
      z_q   <= '0;
    end else begin
      acc_q <= acc_d;
      bit_q <= bit_d;
      z_q   <= z_d;
    end

  assign z_out = z_q;
endmodule

// File: tb/tb_dct_da_bitserial_mac.sv
// tb_dct_da_bitserial_mac: vector table, corner sequences and random triples vs a c2/c6 arithmetic model
module tb_dct_da_bitserial_mac;
  logic               clk = 0;
  logic               rst_n = 0;
  logic               in_valid = 0;
  logic               in_ready;
  logic signed [11:0] xa = 0, xb = 0, xc = 0;
  logic               rom_cs;
  logic [2:0]         rom_addr;
  logic [15:0]        rom_data;
  logic               out_valid;
  logic               out_ready = 0;
  logic signed [27:0] z_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dct_da_bitserial_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xa        (xa),
    .xb        (xb),
    .xc        (xc),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_out     (z_out)
  );

  localparam int C2 = 15137;
  localparam int C6 = 6269;

  // Z6 ROM: word at {a,b,c} is c2*a - c2*b + c6*c
  function automatic logic [15:0] rom_word(input logic [2:0] adr);
    int v;
    v = (adr[2] ? C2 : 0) - (adr[1] ? C2 : 0) + (adr[0] ? C6 : 0);
    return 16'(v);
  endfunction
  assign rom_data = rom_word(rom_addr);

  function automatic longint golden(input int a, input int b, input int c);
    return longint'(C2) * a - longint'(C2) * b + longint'(C6) * c;
  endfunction

  task automatic check(input string nm, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Called at a negedge. Presents a triple, checks latency, result, stall stability and release.
  task automatic do_triple(input logic signed [11:0] a, input logic signed [11:0] b,
                           input logic signed [11:0] c, input int stall, input longint exp,
                           input string nm);
    int n;
    logic signed [27:0] z0;
    xa = a; xb = b; xc = c; in_valid = 1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      check({nm, "_accept_timeout"}, 0, 1);
      in_valid = 0;
      return;
    end
    @(negedge clk);
    in_valid = 0;
    xa = 12'($urandom); xb = 12'($urandom); xc = 12'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check({nm, "_latency"}, n, 12);
    if (!out_valid) return;
    check({nm, "_z"}, z_out, exp);
    z0 = z_out;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({nm, "_stall_valid"}, out_valid, 1);
      check({nm, "_stall_z"}, z_out, z0);
      check({nm, "_stall_in_ready"}, in_ready, 0);
      check({nm, "_stall_rom_cs"}, {rom_cs, rom_addr}, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check({nm, "_released_valid"}, out_valid, 0);
    check({nm, "_released_in_ready"}, in_ready, 1);
    check({nm, "_held_z"}, z_out, z0);
  endtask

  typedef struct {
    logic signed [11:0] a, b, c;
    longint             exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{a: 1,  b: 0, c: 0,     exp: 15137};
    vecs[1] = '{a: 0,  b: 0, c: 1,     exp: 6269};
    vecs[2] = '{a: -1, b: 0, c: 0,     exp: -15137};
    vecs[3] = '{a: 5,  b: 5, c: 0,     exp: 0};
    vecs[4] = '{a: 0,  b: 0, c: 2047,  exp: 12832643};
    vecs[5] = '{a: 0,  b: 0, c: -2048, exp: -12838912};

    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_z", z_out, 0);
    check("reset_rom", {rom_cs, rom_addr}, 0);

    rst_n = 1;
    xa = 1; xb = 0; xc = 0; in_valid = 1;
    #1 check("wake_in_ready", in_ready, 0);
    do_triple(1, 0, 0, 0, 15137, "first");

    foreach (vecs[i]) do_triple(vecs[i].a, vecs[i].b, vecs[i].c, 0, vecs[i].exp, $sformatf("vec%0d", i));

    do_triple(3, -7, 100, 5, golden(3, -7, 100), "stall5");

    xa = 12'sd1000; xb = -12'sd3; xc = 12'sd77; in_valid = 1;
    for (int n = 0; n < 20 && !in_ready; n++) @(negedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (5) @(negedge clk);
    check("abort_in_run", rom_cs, 1);
    rst_n = 0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_rom", {rom_cs, rom_addr}, 0);
    check("abort_z", z_out, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (out_valid) check("abort_no_result", out_valid, 0);
    end
    check("abort_idle", in_ready, 1);
    do_triple(0, 0, 1, 0, 6269, "after_abort");

    for (int i = 0; i < 1000; i++) begin
      logic signed [11:0] a, b, c;
      a = 12'($urandom); b = 12'($urandom); c = 12'($urandom);
      do_triple(a, b, c, int'($urandom_range(0, 3)), golden(a, b, c), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
